timer_input_ctrl: RTL
=====================

TIMER_INPUT_CTRL -- requirements
Module: timer_input_ctrl

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 1000000, number of consecutive stable cycles required to accept an input change (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 Port: CLK_50MHz  input  1  sole clock, all registers update on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port: KeyStartStop  input  1  raw push-button, asynchronous to the clock, active-low, bouncy.
REQ-005 Port: KeyClear  input  1  raw push-button, asynchronous to the clock, active-low, bouncy.
REQ-006 Port: SwMode  input  1  raw slide switch, asynchronous to the clock, 1 = countdown mode, bouncy.
REQ-007 Port: StartStop  output  1  run level to the timer core, 1 = counting.
REQ-008 Port: ModeSel  output  1  debounced mode level to the timer core.
REQ-009 Port: ClearPulse  output  1  single-cycle request to reload/zero the timer core.
REQ-010 Port: ModeChangePulse  output  1  single-cycle flag marking an accepted mode change.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-012 Each synchronized input SHALL have its own debounce counter and debounced-state register.
REQ-013 Debounce: counter increments each cycle the synchronized value differs from the debounced state; it clears to 0 on any cycle the values match.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the debounced state SHALL take the synchronized value and the counter SHALL clear to 0.
REQ-015 Counter width: ceil(log2(DEBOUNCE_CYCLES)) bits; it never wraps.
REQ-016 Press event: debounced key state transitions 1->0; release transitions produce no event.
REQ-017 Latency: a raw change first captured at edge N, held stable, SHALL produce its output effect at edge N+DEBOUNCE_CYCLES+2, exactly.
REQ-018 StartStop press event SHALL toggle StartStop.
REQ-019 KeyClear press event SHALL force StartStop to 0 and assert ClearPulse for exactly one cycle.
REQ-020 Accepted SwMode change SHALL update ModeSel, force StartStop to 0, and assert ModeChangePulse and ClearPulse for exactly one cycle each, in the same cycle.
REQ-021 Priority on coincident events in one cycle: mode change > clear > start/stop; lower-priority events in that cycle are discarded, not deferred.
REQ-022 A key held low indefinitely SHALL produce exactly one event; a new event requires release to be accepted first.
REQ-023 Pulses SHALL never be asserted on consecutive cycles from a single input change.
REQ-024 Bounces shorter than DEBOUNCE_CYCLES cycles SHALL produce no output change.

Reset
REQ-025 While rst_n is sampled 0: StartStop=0, ModeSel=0, ClearPulse=0, ModeChangePulse=0, all counters=0.
REQ-026 Reset values of synchronizer and debounced-state registers: 1 for both keys, 0 for SwMode.
REQ-027 If SwMode is 1 at reset release, a normal mode change (REQ-020) SHALL occur at the REQ-017 latency.
REQ-028 Reset asserted mid-debounce SHALL discard the pending change; after release, debouncing restarts from count 0.

Verification (DEBOUNCE_CYCLES=8)
REQ-029 Reset: rst_n=0 for 3 cycles, keys=1, SwMode=0 -> all outputs 0; outputs stay 0 for 20 cycles after release.
REQ-030 Clean press: KeyStartStop low at edge N for 20 cycles -> StartStop=1 at N+10, holds after release; second identical press -> StartStop=0 at its N+10.
REQ-031 Bounce: KeyStartStop toggles every 3 cycles for 30 cycles, then held low from edge M -> exactly one toggle of StartStop, at M+10.
REQ-032 Clear while running: StartStop=1, KeyClear low at N held 15 cycles -> ClearPulse=1 only at N+10, StartStop=0 at N+10.
REQ-033 Coincident: SwMode 0->1 and KeyStartStop low at same edge N -> at N+10 ModeSel=1, ModeChangePulse=1, ClearPulse=1 (one cycle each), StartStop=0.
REQ-034 Reset mid-debounce: KeyStartStop low at N, rst_n=0 at N+5 for 1 cycle, key held low -> no toggle at N+10; StartStop=1 at (N+6)+10.

Source files
------------

// File: rtl/timer_input_ctrl.sv
// timer_input_ctrl: synchronizes, debounces and decodes the timer's start/stop, clear and mode inputs
module timer_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLK_50MHz,
  input  logic rst_n,
  input  logic KeyStartStop,
  input  logic KeyClear,
  input  logic SwMode,
  output logic StartStop,
  output logic ModeSel,
  output logic ClearPulse,
  output logic ModeChangePulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Bit order {SwMode, KeyClear, KeyStartStop}: keys idle high, switch idles low
  localparam logic [2:0] IDLE = 3'b011;
  logic [2:0] w_raw;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_db;
  logic [2:0] r_db_d;
  logic [CW-1:0] r_cnt [3];
  logic w_ss_ev;
  logic w_clr_ev;
  logic w_mode_ev;
  assign w_raw = {SwMode, KeyClear, KeyStartStop};
  assign w_ss_ev = r_db_d[0] & ~r_db[0];
  assign w_clr_ev = r_db_d[1] & ~r_db[1];
  assign w_mode_ev = r_db_d[2] ^ r_db[2];
  // Two-flop synchronizers, then a per-input stability counter that accepts a change after DEBOUNCE_CYCLES differing cycles
  always_ff @(posedge CLK_50MHz) begin
    if (!rst_n) begin
      r_s1 <= IDLE;
      r_s2 <= IDLE;
      r_db <= IDLE;
      r_db_d <= IDLE;
      for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_db_d <= r_db;
      for (int i = 0; i < 3; i++) begin
        if (r_s2[i] == r_db[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == LAST) begin
          r_db[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end
  // Registered outputs: a mode change outranks clear, which outranks start/stop; losers in a cycle are dropped
  always_ff @(posedge CLK_50MHz) begin
    if (!rst_n) begin
      StartStop <= 1'b0;
      ModeSel <= 1'b0;
      ClearPulse <= 1'b0;
      ModeChangePulse <= 1'b0;
    end else begin
      ClearPulse <= w_mode_ev | w_clr_ev;
      ModeChangePulse <= w_mode_ev;
      if (w_mode_ev) ModeSel <= r_db[2];
      StartStop <= (w_mode_ev | w_clr_ev) ? 1'b0 : StartStop ^ w_ss_ev;
    end
  end
endmodule
